axi_sram_slave: RTL and testbench
=================================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter ID_WID, default 4: width of every AXI ID field.
REQ-002 SHALL have parameter MEM_AW, default 10: word-address width of the internal memory, which holds 2^MEM_AW 32-bit words.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port arid  in  ID_WID  read request ID.
REQ-006 SHALL have port araddr  in  32  read byte address; bits [1:0] ignored.
REQ-007 SHALL have port arlen  in  8  read beats minus one.
REQ-008 SHALL have port arvalid  in  1  read request valid.
REQ-009 SHALL have port arready  out  1  read request accepted.
REQ-010 SHALL have port rid  out  ID_WID  read response ID.
REQ-011 SHALL have port rdata  out  32  read data.
REQ-012 SHALL have port rresp  out  2  read response; constant 2'b00.
REQ-013 SHALL have port rlast  out  1  final read beat.
REQ-014 SHALL have port rvalid  out  1  read beat valid.
REQ-015 SHALL have port rready  in  1  read beat accepted.
REQ-016 SHALL have port awid  in  ID_WID  write request ID.
REQ-017 SHALL have port awaddr  in  32  write byte address; bits [1:0] ignored.
REQ-018 SHALL have port awlen  in  8  write beats minus one.
REQ-019 SHALL have port awvalid  in  1  write request valid.
REQ-020 SHALL have port awready  out  1  write request accepted.
REQ-021 SHALL have port wdata  in  32  write data.
REQ-022 SHALL have port wstrb  in  4  byte enables; bit n covers wdata[8n+7:8n].
REQ-023 SHALL have port wlast  in  1  initiator's final-beat marker.
REQ-024 SHALL have port wvalid  in  1  write beat valid.
REQ-025 SHALL have port wready  out  1  write beat accepted.
REQ-026 SHALL have port bid  out  ID_WID  write response ID.
REQ-027 SHALL have port bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
REQ-028 SHALL have port bvalid  out  1  write response valid.
REQ-029 SHALL have port bready  in  1  write response accepted.

Function
REQ-030 SHALL implement a state machine with states IDLE, RD, WR and WB, exactly one transaction in flight, and burst type always INCR with full-word beats.
REQ-031 In IDLE, SHALL grant read when arvalid && (!awvalid || prio_rd) and grant write otherwise when awvalid; arready and awready SHALL be combinational, high only in IDLE for the granted channel.
REQ-032 SHALL toggle prio_rd after every grant made while arvalid and awvalid are both high, so simultaneous requests alternate.
REQ-033 On an AR handshake, SHALL latch arid and arlen, set the word index to araddr[MEM_AW+1:2], load rdata from memory at that index, assert rvalid on the next cycle and enter RD.
REQ-034 In RD, rid, rdata and rlast SHALL stay stable while rvalid && !rready.
REQ-035 On each non-final R handshake in RD, SHALL increment the index and load the next word, keeping rvalid high, so a continuously high rready yields one beat per cycle.
REQ-036 SHALL assert rlast only on beat arlen+1; the R handshake of that beat SHALL clear rvalid and return to IDLE.
REQ-037 On an AW handshake, SHALL latch awid, awlen and awaddr[MEM_AW+1:2], clear the beat counter and error flag, and enter WR with wready high; wready SHALL be low in every other state.
REQ-038 Each W handshake SHALL write the bytes enabled by wstrb at the current index, leave the other bytes unchanged, and then increment the index.
REQ-039 SHALL set the error flag when wlast is high on a beat other than beat awlen+1 or low on beat awlen+1; all awlen+1 beats SHALL still be written.
REQ-040 After beat awlen+1, SHALL enter WB with bvalid=1, bid set to the latched ID, and bresp=2'b10 if the error flag is set, else 2'b00.
REQ-041 In WB, a B handshake SHALL clear bvalid and return to IDLE.
REQ-042 The word index SHALL wrap modulo 2^MEM_AW; address bits above MEM_AW+1 SHALL be ignored.
REQ-043 A read following a write to the same word SHALL return the written data, since the write completes before B is issued.

Reset
REQ-044 While resetn is low, SHALL immediately force state to IDLE, all outputs to 0 and prio_rd to 1, abandon any in-flight burst, and leave memory contents unchanged.

Verification
REQ-045 Write 0x10, len 0, data 0xDEADBEEF, wstrb 0xF, wlast 1, awid 2 -> bvalid, bid 2, bresp 0; then read 0x10, arid 3 -> next cycle rvalid, rdata 0xDEADBEEF, rlast 1, rid 3.
REQ-046 Write 0x11223344 to 0x20, then data 0x0000AA00 with wstrb 4'b0010 -> read of 0x20 returns 0x1122AA44.
REQ-047 Four-beat read, rready 1,0,1,1,0,1 -> rdata held while stalled, rlast only on the fourth beat, returns to IDLE.
REQ-048 arvalid and awvalid both high after reset -> read granted first; both still pending afterwards -> write granted next.
REQ-049 awlen 3 with wlast high on beat 2 -> bresp 2'b10 and all four words written; with MEM_AW 10, address 0xFFC, len 1 -> second beat lands on word 0.
REQ-050 resetn pulled low mid-RD burst -> rvalid 0 within the same cycle; the next AR is accepted normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_sram_slave
// Purpose  : AXI slave backed by an internal 2^MEM_AW x 32-bit SRAM. Handles
//            one INCR, full-word burst at a time (read or write), arbitrating
//            between simultaneous AR and AW requests by alternating priority.
// Ports    : clk, resetn (async, active-low)
//            AR : arid, araddr, arlen, arvalid -> arready
//            R  : rid, rdata, rresp, rlast, rvalid <- rready
//            AW : awid, awaddr, awlen, awvalid -> awready
//            W  : wdata, wstrb, wlast, wvalid -> wready
//            B  : bid, bresp, bvalid <- bready
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_slave #(
  parameter int ID_WID = 4,
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              resetn,
  // read address channel
  input  logic [ID_WID-1:0] arid,
  input  logic [31:0]       araddr,
  input  logic [7:0]        arlen,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [ID_WID-1:0] rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [ID_WID-1:0] awid,
  input  logic [31:0]       awaddr,
  input  logic [7:0]        awlen,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [ID_WID-1:0] bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam int c_DEPTH = 1 << MEM_AW;

  state_t r_state;
  state_t w_state_next;

  logic [31:0]       r_mem [0:c_DEPTH-1];
  logic [MEM_AW-1:0] r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic [ID_WID-1:0] r_wid;
  logic              r_err;
  logic              r_prio_rd;

  logic              w_grant_rd;
  logic              w_r_hs;
  logic              w_w_hs;
  logic              w_b_hs;
  logic              w_last_beat;
  logic              w_beat_err;
  logic [MEM_AW-1:0] w_ar_idx;
  logic [MEM_AW-1:0] w_aw_idx;
  logic [MEM_AW-1:0] w_idx_inc;
  logic [7:0]        w_cnt_inc;
  logic              w_unused_addr_bits;

  // Only the word-index bits of the addresses matter; the rest are dropped,
  // which is what makes the index wrap modulo the memory depth.
  assign w_ar_idx  = araddr[MEM_AW+1:2];
  assign w_aw_idx  = awaddr[MEM_AW+1:2];
  assign w_idx_inc = r_idx + MEM_AW'(1);
  assign w_cnt_inc = r_cnt + 8'd1;
  assign w_unused_addr_bits = ^{araddr[31:MEM_AW+2], araddr[1:0],
                                awaddr[31:MEM_AW+2], awaddr[1:0]};

  // Read wins when it is alone or when it holds priority; write otherwise.
  assign w_grant_rd = arvalid && (!awvalid || r_prio_rd);

  // Ready outputs are gated by resetn so they read 0 during reset even
  // though they are combinational from the request inputs.
  assign arready = resetn && (r_state == IDLE) && w_grant_rd;
  assign awready = resetn && (r_state == IDLE) && !w_grant_rd && awvalid;
  assign wready  = (r_state == WR);
  assign rresp   = 2'b00;

  assign w_r_hs      = (r_state == RD) && rvalid && rready;
  assign w_w_hs      = (r_state == WR) && wvalid;
  assign w_b_hs      = (r_state == WB) && bvalid && bready;
  assign w_last_beat = (r_cnt == r_len);
  // wlast must coincide exactly with the final beat; any disagreement is
  // an initiator protocol error reported as SLVERR.
  assign w_beat_err  = (wlast != w_last_beat);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (arready)      w_state_next = RD;
        else if (awready) w_state_next = WR;
      end
      RD: if (w_r_hs && rlast)       w_state_next = IDLE;
      WR: if (w_w_hs && w_last_beat) w_state_next = WB;
      WB: if (w_b_hs)                w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Burst datapath and channel outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx     <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_wid     <= '0;
      r_err     <= 1'b0;
      r_prio_rd <= 1'b1;
      rid       <= '0;
      rdata     <= '0;
      rlast     <= 1'b0;
      rvalid    <= 1'b0;
      bid       <= '0;
      bresp     <= 2'b00;
      bvalid    <= 1'b0;
    end else begin
      // A collision in IDLE always produces a grant, so flip priority there.
      if ((r_state == IDLE) && arvalid && awvalid)
        r_prio_rd <= !r_prio_rd;

      case (r_state)
        IDLE: begin
          if (arready) begin
            rid    <= arid;
            r_len  <= arlen;
            r_cnt  <= '0;
            r_idx  <= w_ar_idx;
            rdata  <= r_mem[w_ar_idx];
            rvalid <= 1'b1;
            rlast  <= (arlen == 8'd0);
          end else if (awready) begin
            r_wid <= awid;
            r_len <= awlen;
            r_cnt <= '0;
            r_idx <= w_aw_idx;
            r_err <= 1'b0;
          end
        end

        RD: begin
          if (w_r_hs) begin
            if (rlast) begin
              rvalid <= 1'b0;
              rlast  <= 1'b0;
            end else begin
              // Prefetch the next word so rready held high gives a beat
              // every cycle.
              r_idx <= w_idx_inc;
              r_cnt <= w_cnt_inc;
              rdata <= r_mem[w_idx_inc];
              rlast <= (w_cnt_inc == r_len);
            end
          end
        end

        WR: begin
          if (w_w_hs) begin
            r_idx <= w_idx_inc;
            r_cnt <= w_cnt_inc;
            r_err <= r_err | w_beat_err;
            if (w_last_beat) begin
              bvalid <= 1'b1;
              bid    <= r_wid;
              bresp  <= (r_err | w_beat_err) ? 2'b10 : 2'b00;
            end
          end
        end

        WB: begin
          if (w_b_hs) bvalid <= 1'b0;
        end

        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Memory write port; contents are deliberately not reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_w_hs) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) r_mem[r_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_slave
// Purpose  : Directed, self-checking bench for axi_sram_slave. Inputs change
//            and outputs are sampled on the falling clock edge; handshakes
//            happen on the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_slave;

  localparam int ID_WID = 4;
  localparam int MEM_AW = 10;

  logic              clk = 1'b0;
  logic              resetn;
  logic [ID_WID-1:0] arid;
  logic [31:0]       araddr;
  logic [7:0]        arlen;
  logic              arvalid;
  logic              arready;
  logic [ID_WID-1:0] rid;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [ID_WID-1:0] awid;
  logic [31:0]       awaddr;
  logic [7:0]        awlen;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [ID_WID-1:0] bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  int n_checks = 0;
  int n_errors = 0;

  // Per-beat stimulus and expected read data for the burst tasks.
  logic [31:0] vec_d [0:7];
  logic [3:0]  vec_s [0:7];
  logic        vec_l [0:7];
  logic [31:0] exp_r [0:7];

  always #5 clk = ~clk;

  axi_sram_slave #(.ID_WID(ID_WID), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks below are entered and left at a falling edge.
  task automatic do_ar(input logic [31:0] addr, input logic [ID_WID-1:0] id,
                       input logic [7:0] len);
    int k;
    araddr = addr; arid = id; arlen = len; arvalid = 1'b1;
    #1; k = 0;
    while (!arready && k < 32) begin @(negedge clk); #1; k++; end
    check("ar_accept", 32'(arready), 32'd1);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic do_aw(input logic [31:0] addr, input logic [ID_WID-1:0] id,
                       input logic [7:0] len);
    int k;
    awaddr = addr; awid = id; awlen = len; awvalid = 1'b1;
    #1; k = 0;
    while (!awready && k < 32) begin @(negedge clk); #1; k++; end
    check("aw_accept", 32'(awready), 32'd1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic write_burst(input logic [31:0] addr,
                             input logic [ID_WID-1:0] id,
                             input logic [7:0] len, input logic [1:0] exp_resp);
    int k;
    do_aw(addr, id, len);
    for (int i = 0; i <= int'(len); i++) begin
      wdata = vec_d[i]; wstrb = vec_s[i]; wlast = vec_l[i]; wvalid = 1'b1;
      #1; k = 0;
      while (!wready && k < 32) begin @(negedge clk); #1; k++; end
      check($sformatf("wready[%0d]", i), 32'(wready), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    k = 0;
    while (!bvalid && k < 32) begin @(negedge clk); k++; end
    check("bvalid", 32'(bvalid), 32'd1);
    check("bid", 32'(bid), 32'(id));
    check("bresp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    check("bvalid_clr", 32'(bvalid), 32'd0);
  endtask

  task automatic read_burst(input logic [31:0] addr,
                            input logic [ID_WID-1:0] id, input logic [7:0] len);
    int k;
    do_ar(addr, id, len);
    for (int i = 0; i <= int'(len); i++) begin
      k = 0;
      while (!rvalid && k < 32) begin @(negedge clk); k++; end
      check($sformatf("rvalid[%0d]", i), 32'(rvalid), 32'd1);
      check($sformatf("rdata[%0d]", i), rdata, exp_r[i]);
      check($sformatf("rlast[%0d]", i), 32'(rlast), 32'(i == int'(len)));
      check($sformatf("rid[%0d]", i), 32'(rid), 32'(id));
      rready = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    rready = 1'b0;
    check("rvalid_clr", 32'(rvalid), 32'd0);
  endtask

  // Read-stall pattern for the four-beat burst.
  logic rr_pat [0:5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    int beat;
    resetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // ---- simultaneous AR/AW after reset: read first, then write ----
    araddr = 32'h80; arid = 4'd1; arlen = 8'd0; arvalid = 1'b1;
    awaddr = 32'h84; awid = 4'd5; awlen = 8'd0; awvalid = 1'b1;
    #1;
    check("arb1_arready", 32'(arready), 32'd1);
    check("arb1_awready", 32'(awready), 32'd0);
    @(posedge clk); @(negedge clk);
    check("arb_rd_arready", 32'(arready), 32'd0);
    check("arb_rd_awready", 32'(awready), 32'd0);
    check("arb_rvalid", 32'(rvalid), 32'd1);
    check("arb_rlast", 32'(rlast), 32'd1);
    check("arb_rid", 32'(rid), 32'd1);
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    #1;
    check("arb2_awready", 32'(awready), 32'd1);
    check("arb2_arready", 32'(arready), 32'd0);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0;
    wdata = 32'h5A5A_5A5A; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    check("arb_wready", 32'(wready), 32'd1);
    @(posedge clk); @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
    check("arb_bvalid", 32'(bvalid), 32'd1);
    check("arb_bid", 32'(bid), 32'd5);
    check("arb_bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;

    // ---- single write then read back ----
    vec_d[0] = 32'hDEAD_BEEF; vec_s[0] = 4'hF; vec_l[0] = 1'b1;
    write_burst(32'h10, 4'd2, 8'd0, 2'b00);
    exp_r[0] = 32'hDEAD_BEEF;
    read_burst(32'h10, 4'd3, 8'd0);
    exp_r[0] = 32'h5A5A_5A5A;
    read_burst(32'h84, 4'd4, 8'd0);

    // ---- byte strobes ----
    vec_d[0] = 32'h1122_3344; vec_s[0] = 4'hF; vec_l[0] = 1'b1;
    write_burst(32'h20, 4'd1, 8'd0, 2'b00);
    vec_d[0] = 32'h0000_AA00; vec_s[0] = 4'b0010; vec_l[0] = 1'b1;
    write_burst(32'h20, 4'd1, 8'd0, 2'b00);
    exp_r[0] = 32'h1122_AA44;
    read_burst(32'h20, 4'd7, 8'd0);

    // ---- four-beat read with stalls ----
    for (int i = 0; i < 4; i++) begin
      vec_d[i] = 32'hA000_0000 + 32'(i); vec_s[i] = 4'hF; vec_l[i] = (i == 3);
    end
    write_burst(32'h40, 4'd9, 8'd3, 2'b00);
    do_ar(32'h40, 4'd8, 8'd3);
    beat = 0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("stall_rvalid[%0d]", i), 32'(rvalid), 32'd1);
      check($sformatf("stall_rdata[%0d]", i), rdata, 32'hA000_0000 + 32'(beat));
      check($sformatf("stall_rlast[%0d]", i), 32'(rlast), 32'(beat == 3));
      rready = rr_pat[i];
      @(posedge clk); @(negedge clk);
      if (rr_pat[i]) beat++;
    end
    rready = 1'b0;
    check("stall_rvalid_end", 32'(rvalid), 32'd0);
    check("stall_beats", 32'(beat), 32'd4);
    arvalid = 1'b1; araddr = 32'h40; arlen = 8'd0; #1;
    check("stall_idle_arready", 32'(arready), 32'd1);
    arvalid = 1'b0; #1;

    // ---- early wlast -> SLVERR, all four words still written ----
    for (int i = 0; i < 4; i++) begin
      vec_d[i] = 32'hC000_0000 + 32'(i); vec_s[i] = 4'hF; vec_l[i] = (i == 1);
    end
    write_burst(32'h100, 4'd6, 8'd3, 2'b10);
    for (int i = 0; i < 4; i++) exp_r[i] = 32'hC000_0000 + 32'(i);
    read_burst(32'h100, 4'd6, 8'd3);

    // ---- index wrap at the top of memory ----
    vec_d[0] = 32'h1111_1111; vec_s[0] = 4'hF; vec_l[0] = 1'b0;
    vec_d[1] = 32'h2222_2222; vec_s[1] = 4'hF; vec_l[1] = 1'b1;
    write_burst(32'hFFC, 4'd3, 8'd1, 2'b00);
    exp_r[0] = 32'h2222_2222;
    read_burst(32'h0, 4'd2, 8'd0);
    read_burst(32'h1000, 4'd2, 8'd0);
    exp_r[0] = 32'h1111_1111; exp_r[1] = 32'h2222_2222;
    read_burst(32'hFFC, 4'd2, 8'd1);

    // ---- reset mid read burst ----
    do_ar(32'h40, 4'd5, 8'd3);
    rready = 1'b1;
    @(posedge clk); @(negedge clk);
    rready = 1'b0;
    check("mid_rdata", rdata, 32'hA000_0001);
    resetn = 1'b0;
    #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_rlast", 32'(rlast), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    exp_r[0] = 32'hDEAD_BEEF;
    read_burst(32'h10, 4'd6, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
